// File: rtl/hi_lo_mult_div.sv
// Iterative MIPS multiply/divide unit that owns the HI/LO registers.
// Shift-add multiply and restoring divide run on operand magnitudes; one final cycle fixes the signs.
module hi_lo_mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic               isDiv_q, isDiv_d;
    logic               negLo_q, negLo_d;
    logic               negHi_q, negHi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               rsNeg, rtNeg;
    logic [WIDTH-1:0]   rsMag, rtMag;
    logic [WIDTH:0]     mulSum, divCand, divDiff;
    logic [2*WIDTH-1:0] mulNext, divNext, prodFixed;

    // Magnitudes of 0x8000_0000 wrap to themselves, which is exactly unsigned 2^(WIDTH-1).
    assign rsNeg = op[0] & rs_data[WIDTH-1];
    assign rtNeg = op[0] & rt_data[WIDTH-1];
    assign rsMag = rsNeg ? -rs_data : rs_data;
    assign rtMag = rtNeg ? -rt_data : rt_data;

    // Multiply: upper half accumulates, multiplier bits are consumed from the bottom of work_q.
    assign mulSum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, operand_q} : '0);
    assign mulNext = {mulSum, work_q[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, quotient bits shift in from the bottom.
    assign divCand = work_q[2*WIDTH-1:WIDTH-1];
    assign divDiff = divCand - {1'b0, operand_q};
    assign divNext = divDiff[WIDTH] ? {divCand[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                    : {divDiff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

    assign prodFixed = negLo_q ? -work_q : work_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            work_q    <= '0;
            operand_q <= '0;
            isDiv_q   <= 1'b0;
            negLo_q   <= 1'b0;
            negHi_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            work_q    <= work_d;
            operand_q <= operand_d;
            isDiv_q   <= isDiv_d;
            negLo_q   <= negLo_d;
            negHi_q   <= negHi_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        work_d    = work_q;
        operand_d = operand_q;
        isDiv_d   = isDiv_q;
        negLo_d   = negLo_q;
        negHi_d   = negHi_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    count_d = '0;
                    isDiv_d = op[1];
                    if (op[1]) begin
                        work_d    = {{WIDTH{1'b0}}, rsMag};
                        operand_d = rtMag;
                        // A zero divisor leaves the all-ones quotient unsigned.
                        negLo_d   = (rsNeg ^ rtNeg) & (rt_data != '0);
                        negHi_d   = rsNeg;
                    end else begin
                        work_d    = {{WIDTH{1'b0}}, rtMag};
                        operand_d = rsMag;
                        negLo_d   = rsNeg ^ rtNeg;
                        negHi_d   = 1'b0;
                    end
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            CALC: begin
                work_d  = isDiv_q ? divNext : mulNext;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (isDiv_q) begin
                    lo_d = negLo_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
                    hi_d = negHi_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = prodFixed;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_hi_lo_mult_div.sv
// Self-checking bench for hi_lo_mult_div: a cycle-level reference model built on plain 64-bit
// arithmetic is compared against the DUT every cycle, plus literal checks of known results.
module tb_hi_lo_mult_div;
    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int errors = 0;
    int checks = 0;
    logic compareOn = 1'b0;

    hi_lo_mult_div #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
        .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Architectural result {hi, lo} of one operation, from signed/unsigned integer arithmetic.
    function automatic logic [63:0] refResult(input logic [1:0] fop, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        r  = '0;
        case (fop)
            2'b00: r = {32'b0, a} * {32'b0, b};
            2'b01: r = 64'(sa * sb);
            2'b10: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
        endcase
        return r;
    endfunction

    logic [31:0] mHi = '0, mLo = '0;
    logic        mDone = 1'b0;
    int          mLeft = 0;
    logic [63:0] mPending = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mHi <= '0; mLo <= '0; mDone <= 1'b0; mLeft <= 0;
        end else begin
            mDone <= 1'b0;
            if (mLeft > 0) begin
                mLeft <= mLeft - 1;
                if (mLeft == 1) begin
                    {mHi, mLo} <= mPending;
                    mDone      <= 1'b1;
                end
            end else if (start) begin
                mPending <= refResult(op, rs_data, rt_data);
                mLeft    <= LAT;
            end else begin
                if (mthi) mHi <= wdata;
                if (mtlo) mLo <= wdata;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (compareOn) begin
            checkOutput("cyc hi", hi, mHi);
            checkOutput("cyc lo", lo, mLo);
            checkOutput("cyc busy", 32'(busy), 32'(mLeft > 0));
            checkOutput("cyc done", 32'(done), 32'(mDone));
        end
    end

    // Called at posedge+1; the next posedge samples start.
    task automatic launchOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; rs_data = $urandom; rt_data = $urandom;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 1;
        while (!done && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done timeout: got no done after %0d cycles, expected %0d", cycles, LAT + 1);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expHi,
                                 input logic [31:0] expLo);
        int cyc;
        launchOp(o, a, b);
        waitDone(cyc);
        checkOutput({name, " hi"}, hi, expHi);
        checkOutput({name, " lo"}, lo, expLo);
        checkOutput({name, " model"}, refResult(o, a, b)[31:0], expLo);
    endtask

    initial begin
        int cyc;
        #1 reset_n = 1'b0;
        #2 compareOn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset hi", hi, 32'h0);
        checkOutput("reset lo", lo, 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        reset_n = 1'b1;

        launchOp(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(cyc);
        checkOutput("multu latency", 32'(cyc), 32'(LAT + 1));
        checkOutput("multu max hi", hi, 32'hFFFF_FFFE);
        checkOutput("multu max lo", lo, 32'h0000_0001);

        applyStimulus("mult -3*5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        applyStimulus("mult min*min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        applyStimulus("mult -1*-1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
        applyStimulus("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        applyStimulus("div 7/-2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
        applyStimulus("div ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        applyStimulus("div -7/0", 2'b11, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        launchOp(2'b10, 32'd100, 32'd0);
        waitDone(cyc);
        checkOutput("divu by0 latency", 32'(cyc), 32'(LAT + 1));
        checkOutput("divu by0 hi", hi, 32'h0000_0064);
        checkOutput("divu by0 lo", lo, 32'hFFFF_FFFF);
        applyStimulus("divu 100/7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);

        // MT* and a second start while busy must leave the running MULTU untouched.
        launchOp(2'b00, 32'd3, 32'd4);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b1; op = 2'b11; rs_data = 32'd9; rt_data = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        waitDone(cyc);
        checkOutput("busy mt hi", hi, 32'h0);
        checkOutput("busy mt lo", lo, 32'd12);

        mtlo = 1'b1; wdata = 32'hABCD;
        @(posedge clk); #1;
        mtlo = 1'b0;
        checkOutput("mtlo lo", lo, 32'hABCD);
        checkOutput("mtlo hi", hi, 32'h0);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5555;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        checkOutput("mthilo hi", hi, 32'h5555);
        checkOutput("mthilo lo", lo, 32'h5555);

        mthi = 1'b1; wdata = 32'hDEAD;
        launchOp(2'b00, 32'd2, 32'd3);
        mthi = 1'b0;
        waitDone(cyc);
        checkOutput("start+mthi hi", hi, 32'h0);
        checkOutput("start+mthi lo", lo, 32'd6);

        applyStimulus("pre-reset", 2'b00, 32'd7, 32'd9, 32'h0, 32'd63);
        launchOp(2'b01, 32'hFFFF_FFFD, 32'd5);
        repeat (9) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        checkOutput("abort hi", hi, 32'h0);
        checkOutput("abort lo", lo, 32'h0);
        checkOutput("abort busy", 32'(busy), 32'h0);
        checkOutput("abort done", 32'(done), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        launchOp(2'b00, 32'd6, 32'd7);
        waitDone(cyc);
        checkOutput("post-reset latency", 32'(cyc), 32'(LAT + 1));
        checkOutput("post-reset lo", lo, 32'd42);
        checkOutput("post-reset hi", hi, 32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
